// File: rtl/ocx_tlx_dhf_pkg.sv
// Shared constants and helpers for the TLX data hold FIFO.
// Pointers carry one extra wrap bit so that occupancy == DEPTH is distinct from empty.
package ocx_tlx_dhf_pkg;

    localparam int DEPTH   = 32;
    localparam int PTR_W   = 5;
    localparam int MAX_RUN = 8;
    localparam int BDI_W   = 8;
    localparam int FLIT_W  = 512;
    localparam int CNT_W   = 32;

    typedef logic [PTR_W:0] ptr_t;

    function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
        return a - b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [CNT_W-1:0] b
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ocx_tlx_dhf_ram.sv
// DEPTH x 512 storage, one write port and one registered read port.
// Ports: tlx_clk, reset_n (sync, active-low, clears read register), we/waddr/wdata, re/raddr/rdata.
module ocx_tlx_dhf_ram
    import ocx_tlx_dhf_pkg::*;
(
    input  logic              tlx_clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [FLIT_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [FLIT_W-1:0] rdata
);

    logic [FLIT_W-1:0] mem [DEPTH];

    always_ff @(posedge tlx_clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge tlx_clk) begin
        if (!reset_n)  rdata <= '0;
        else if (re)   rdata <= mem[raddr];
    end

endmodule

// File: rtl/ocx_tlx_data_hold_fifo.sv
// Holds parser data flits until a bookend commits the run (with BDI bad bits) or a CRC error discards it; drains committed flits on rd_req.
// Ports: tlx_clk, reset_n, pars_*, bookend_flit_v, bad_data_indicator, crc_error, rd_req, rd_data_*, committed_cnt, fifo_full, ovf_err, run_err; OCX_TLX_DHF_PERF_CNT_EN adds perf_cmt_flits/perf_drop_flits.
module ocx_tlx_data_hold_fifo
    import ocx_tlx_dhf_pkg::*;
(
    input  logic              tlx_clk,
    input  logic              reset_n,
    input  logic [FLIT_W-1:0] pars_data_flit,
    input  logic              pars_data_valid,
    input  logic              bookend_flit_v,
    input  logic [BDI_W-1:0]  bad_data_indicator,
    input  logic              crc_error,
    input  logic              rd_req,
    output logic [FLIT_W-1:0] rd_data_flit,
    output logic              rd_data_valid,
    output logic              rd_data_bad,
    output logic [PTR_W:0]    committed_cnt,
    output logic              fifo_full,
    output logic              ovf_err,
    output logic              run_err
`ifdef OCX_TLX_DHF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_cmt_flits,
    output logic [CNT_W-1:0]  perf_drop_flits
`endif
);

    ptr_t wr_ptr, cmt_ptr, rd_ptr;
    ptr_t uncmt, cmt_n, wr_dis, wr_n, rd_n, occ, uncmt_n;
    logic wr_en, rd_en, ovf_set, run_set;
    logic [DEPTH-1:0] bad, bad_n;

    // Order within a cycle: commit, then discard, then write.
    always_comb begin
        uncmt   = ptr_diff(wr_ptr, cmt_ptr);
        cmt_n   = bookend_flit_v ? wr_ptr : cmt_ptr;
        wr_dis  = crc_error ? cmt_n : wr_ptr;
        occ     = ptr_diff(wr_dis, rd_ptr);
        wr_en   = pars_data_valid & ~crc_error & (occ != ptr_t'(DEPTH));
        ovf_set = pars_data_valid & ~crc_error & (occ == ptr_t'(DEPTH));
        wr_n    = wr_dis + ptr_t'(wr_en);
        uncmt_n = ptr_diff(wr_n, cmt_n);
        run_set = wr_en & (uncmt_n > ptr_t'(MAX_RUN));
        rd_en   = rd_req & (committed_cnt != '0);
        rd_n    = rd_ptr + ptr_t'(rd_en);
    end

    // BDI bit i maps to the i-th uncommitted entry; index wraps at DEPTH.
    always_comb begin
        bad_n = bad;
        if (bookend_flit_v) begin
            for (int i = 0; i < BDI_W; i++) begin
                if (ptr_t'(i) < uncmt)
                    bad_n[cmt_ptr[PTR_W-1:0] + PTR_W'(i)] = bad_data_indicator[i];
            end
        end
        if (wr_en) bad_n[wr_dis[PTR_W-1:0]] = 1'b0;
    end

    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            cmt_ptr       <= '0;
            rd_ptr        <= '0;
            bad           <= '0;
            committed_cnt <= '0;
            rd_data_valid <= 1'b0;
            rd_data_bad   <= 1'b0;
            ovf_err       <= 1'b0;
            run_err       <= 1'b0;
        end else begin
            wr_ptr        <= wr_n;
            cmt_ptr       <= cmt_n;
            rd_ptr        <= rd_n;
            bad           <= bad_n;
            committed_cnt <= ptr_diff(cmt_n, rd_n);
            rd_data_valid <= rd_en;
            if (rd_en) rd_data_bad <= bad[rd_ptr[PTR_W-1:0]];
            if (ovf_set) ovf_err <= 1'b1;
            if (run_set) run_err <= 1'b1;
        end
    end

    assign fifo_full = (ptr_diff(wr_ptr, rd_ptr) == ptr_t'(DEPTH));

    ocx_tlx_dhf_ram u_ram (
        .tlx_clk (tlx_clk),
        .reset_n (reset_n),
        .we      (wr_en),
        .waddr   (wr_dis[PTR_W-1:0]),
        .wdata   (pars_data_flit),
        .re      (rd_en),
        .raddr   (rd_ptr[PTR_W-1:0]),
        .rdata   (rd_data_flit)
    );

`ifdef OCX_TLX_DHF_PERF_CNT_EN
    logic [CNT_W-1:0] cmt_inc, drop_inc;

    // Drops: uncommitted run thrown away by CRC, a write in the CRC cycle, or a write while full.
    always_comb begin
        cmt_inc  = bookend_flit_v ? CNT_W'(uncmt) : '0;
        drop_inc = CNT_W'(ptr_diff(wr_ptr, wr_dis))
                 + CNT_W'(pars_data_valid & crc_error)
                 + CNT_W'(ovf_set);
    end

    always_ff @(posedge tlx_clk) begin
        if (!reset_n) begin
            perf_cmt_flits  <= '0;
            perf_drop_flits <= '0;
        end else begin
            perf_cmt_flits  <= sat_add(perf_cmt_flits, cmt_inc);
            perf_drop_flits <= sat_add(perf_drop_flits, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_ocx_tlx_data_hold_fifo.sv
// Directed self-checking bench for ocx_tlx_data_hold_fifo.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_ocx_tlx_data_hold_fifo;
    import ocx_tlx_dhf_pkg::*;

    logic              tlx_clk = 1'b0;
    logic              reset_n;
    logic [FLIT_W-1:0] pars_data_flit;
    logic              pars_data_valid;
    logic              bookend_flit_v;
    logic [BDI_W-1:0]  bad_data_indicator;
    logic              crc_error;
    logic              rd_req;
    logic [FLIT_W-1:0] rd_data_flit;
    logic              rd_data_valid;
    logic              rd_data_bad;
    logic [PTR_W:0]    committed_cnt;
    logic              fifo_full;
    logic              ovf_err;
    logic              run_err;
`ifdef OCX_TLX_DHF_PERF_CNT_EN
    logic [31:0]       perf_cmt_flits;
    logic [31:0]       perf_drop_flits;
`endif

    int total = 0;
    int bad   = 0;

    always #5 tlx_clk = ~tlx_clk;

    ocx_tlx_data_hold_fifo dut (
        .tlx_clk            (tlx_clk),
        .reset_n            (reset_n),
        .pars_data_flit     (pars_data_flit),
        .pars_data_valid    (pars_data_valid),
        .bookend_flit_v     (bookend_flit_v),
        .bad_data_indicator (bad_data_indicator),
        .crc_error          (crc_error),
        .rd_req             (rd_req),
        .rd_data_flit       (rd_data_flit),
        .rd_data_valid      (rd_data_valid),
        .rd_data_bad        (rd_data_bad),
        .committed_cnt      (committed_cnt),
        .fifo_full          (fifo_full),
        .ovf_err            (ovf_err),
        .run_err            (run_err)
`ifdef OCX_TLX_DHF_PERF_CNT_EN
        ,
        .perf_cmt_flits     (perf_cmt_flits),
        .perf_drop_flits    (perf_drop_flits)
`endif
    );

    function automatic logic [FLIT_W-1:0] mk(input int n);
        logic [31:0] w;
        w = 32'hA500_0000 + 32'(n);
        return {16{w}};
    endfunction

    task automatic chk(input string tag, input logic [FLIT_W-1:0] obs,
                       input logic [FLIT_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge tlx_clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic wr(input int n);
        pars_data_valid = 1'b1;
        pars_data_flit  = mk(n);
        cyc();
        pars_data_valid = 1'b0;
    endtask

    task automatic bookend(input logic [7:0] bdi);
        bookend_flit_v     = 1'b1;
        bad_data_indicator = bdi;
        cyc();
        bookend_flit_v     = 1'b0;
        bad_data_indicator = '0;
    endtask

    task automatic rd(input string tag, input int n, input logic b);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        chk({tag, "_v"}, rd_data_valid, 1'b1);
        chk({tag, "_d"}, rd_data_flit, mk(n));
        chk({tag, "_b"}, rd_data_bad, b);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_flit"}, rd_data_flit, '0);
        chk({tag, "_val"}, rd_data_valid, 1'b0);
        chk({tag, "_bad"}, rd_data_bad, 1'b0);
        chk({tag, "_cnt"}, committed_cnt, '0);
        chk({tag, "_full"}, fifo_full, 1'b0);
        chk({tag, "_ovf"}, ovf_err, 1'b0);
        chk({tag, "_run"}, run_err, 1'b0);
    endtask

    initial begin
        pars_data_flit     = '0;
        pars_data_valid    = 1'b0;
        bookend_flit_v     = 1'b0;
        bad_data_indicator = '0;
        crc_error          = 1'b0;
        rd_req             = 1'b0;
        do_reset();
        chk_idle("rst");

        // 1: three flits, BDI marks the second bad
        wr(1); wr(2); wr(3);
        chk("s1_cnt_pre", committed_cnt, 0);
        bookend(8'h02);
        chk("s1_cnt", committed_cnt, 3);
        rd("s1_r0", 1, 1'b0);
        rd("s1_r1", 2, 1'b1);
        rd("s1_r2", 3, 1'b0);
        chk("s1_cnt_end", committed_cnt, 0);

        // 6: read request while nothing committed
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        chk("s6_noval", rd_data_valid, 1'b0);
        cyc();
        chk("s6_noval2", rd_data_valid, 1'b0);

        // 2: crc discards the first run
        do_reset();
        wr(10); wr(11);
        crc_error = 1'b1;
        cyc();
        crc_error = 1'b0;
        wr(12); wr(13);
        bookend(8'h00);
        chk("s2_cnt", committed_cnt, 2);
        rd("s2_r0", 12, 1'b0);
        rd("s2_r1", 13, 1'b0);
`ifdef OCX_TLX_DHF_PERF_CNT_EN
        chk("s2_perf_cmt", perf_cmt_flits, 2);
        chk("s2_perf_drop", perf_drop_flits, 2);
`endif

        // 3: bookend and crc together; then write with crc
        wr(20); wr(21); wr(22); wr(23);
        bookend_flit_v = 1'b1;
        crc_error      = 1'b1;
        cyc();
        bookend_flit_v = 1'b0;
        crc_error      = 1'b0;
        chk("s3_cnt", committed_cnt, 4);
        pars_data_valid = 1'b1;
        pars_data_flit  = mk(24);
        crc_error       = 1'b1;
        cyc();
        pars_data_valid = 1'b0;
        crc_error       = 1'b0;
        bookend(8'hFF);
        chk("s3_cnt2", committed_cnt, 4);
        for (int k = 0; k < 4; k++) rd("s3_r", 20 + k, 1'b0);
        chk("s3_cnt_end", committed_cnt, 0);

        // 4: fill, overflow, read one, wrap write
        do_reset();
        for (int k = 0; k < 32; k++) begin
            wr(100 + k);
            if (k % 8 == 7) bookend(8'h00);
        end
        chk("s4_cnt", committed_cnt, 32);
        chk("s4_full", fifo_full, 1'b1);
        chk("s4_ovf_pre", ovf_err, 1'b0);
        chk("s4_run_pre", run_err, 1'b0);
        wr(99);
        chk("s4_ovf", ovf_err, 1'b1);
        chk("s4_full2", fifo_full, 1'b1);
        rd("s4_r0", 100, 1'b0);
        chk("s4_notfull", fifo_full, 1'b0);
        wr(200);
        chk("s4_full3", fifo_full, 1'b1);
        bookend(8'h01);
        chk("s4_cnt2", committed_cnt, 32);
        for (int k = 1; k < 32; k++) rd("s4_r", 100 + k, 1'b0);
        rd("s4_wrap", 200, 1'b1);
        chk("s4_cnt_end", committed_cnt, 0);
        chk("s4_ovf_sticky", ovf_err, 1'b1);

        // 5: overlong run, then reset mid-run
        for (int k = 0; k < 8; k++) wr(300 + k);
        chk("s5_run8", run_err, 1'b0);
        wr(308);
        chk("s5_run9", run_err, 1'b1);
        chk("s5_cnt", committed_cnt, 0);
        do_reset();
        chk_idle("s5_rst");
        bookend(8'h00);
        chk("s5_cnt_after", committed_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
